arm_mem_stall_controller: RTL and testbench

Control unit for the single-cycle ARMv4 datapath. It decodes the fetched instruction into the datapath control word: RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg and PCSrc. It holds the NZCV flag register and evaluates conditional execution. It also stalls the PC and register-file commit while a load/store waits on a data-memory handshake, with a timeout.

---
 rtl/arm_ctrl_pkg.sv | 45 ++++
 rtl/arm_mem_stall_controller_if.sv | 31 +++
 rtl/arm_cond_unit.sv | 54 +++++
 rtl/arm_mem_stall_controller.sv | 178 +++++++++++++++++
 tb/tb_arm_mem_stall_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARMv4 single-cycle control unit: ALU ops, opcode
// classes, data-processing commands, condition codes and FSM states.
package arm_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [0:0] {
    EXEC     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/arm_mem_stall_controller_if.sv
// Instruction/flag inputs, control word outputs and data-memory handshake
// between the control unit (master) and the datapath/memory side (slave).
interface arm_mem_stall_controller_if;
  logic [31:0] Instruction;
  logic [3:0]  ALUFlags;
  logic        mem_ack;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [3:0]  ALUControl;
  logic        MemtoReg;
  logic        PCSrc;
  logic        MemWrite;
  logic        mem_req;
  logic        PCWrite;
  logic [3:0]  Flags;
  logic        mem_err;

  modport master (
    input  Instruction, ALUFlags, mem_ack,
    output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
           MemWrite, mem_req, PCWrite, Flags, mem_err
  );

  modport slave (
    output Instruction, ALUFlags, mem_ack,
    input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
           MemWrite, mem_req, PCWrite, Flags, mem_err
  );
endinterface

// File: rtl/arm_cond_unit.sv
// NZCV flag register and condition evaluation; flag writes are masked so
// logical ops touch only N/Z while arithmetic ops load all four.
module arm_cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       wr_nz,
  input  logic       wr_cv,
  output logic [3:0] flags,
  output logic       cond_ex
);
  logic [3:0] flags_d, flags_q;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // New flags only become visible to the following instruction's condition.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && wr_nz) flags_d[3:2] = alu_flags[3:2];
    if (cond_ex && wr_cv) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
endmodule

// File: rtl/arm_mem_stall_controller.sv
// ARMv4 control unit: instruction decode, conditional execution and a
// two-state stall FSM for the data-memory request/acknowledge handshake.
module arm_mem_stall_controller
  import arm_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  arm_mem_stall_controller_if.master    bus
);
  localparam logic [CNT_W:0] TMO_LIM = (CNT_W+1)'(MEM_TIMEOUT);

  logic [1:0] op;
  logic [3:0] cmd;
  logic       i_bit, s_bit, l_bit, u_bit, rd15;
  logic       is_mem, is_b;
  logic [1:0] reg_src, imm_src;
  logic       alu_src;
  logic [3:0] alu_ctl;
  logic       writes_rd, arith, cmd_ok;
  logic       wr_nz, wr_cv, cond_ex;
  logic [3:0] flags;
  logic       reg_write, pc_write, pc_src, mem_write, mem_req, mem_to_reg;
  state_e     state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W:0]   cnt_inc;
  logic       err_d, err_q, tmo_hit;
  logic       unused_instr;

  assign op     = bus.Instruction[27:26];
  assign cmd    = bus.Instruction[24:21];
  assign i_bit  = bus.Instruction[25];
  assign s_bit  = bus.Instruction[20];
  assign l_bit  = bus.Instruction[20];
  assign u_bit  = bus.Instruction[23];
  assign rd15   = (bus.Instruction[15:12] == 4'hF);
  assign is_mem = (op == OP_MEM);
  assign is_b   = (op == OP_B);
  assign unused_instr = ^{bus.Instruction[19:16], bus.Instruction[11:0]};

  always_comb begin
    reg_src   = 2'b00;
    imm_src   = 2'b00;
    alu_src   = 1'b0;
    alu_ctl   = ALU_ADD;
    writes_rd = 1'b0;
    arith     = 1'b0;
    cmd_ok    = 1'b0;
    case (op)
      OP_DP: begin
        alu_src = i_bit;
        cmd_ok  = 1'b1;
        case (cmd)
          CMD_ADD: begin alu_ctl = ALU_ADD; writes_rd = 1'b1; arith = 1'b1; end
          CMD_SUB: begin alu_ctl = ALU_SUB; writes_rd = 1'b1; arith = 1'b1; end
          CMD_AND: begin alu_ctl = ALU_AND; writes_rd = 1'b1; end
          CMD_ORR: begin alu_ctl = ALU_ORR; writes_rd = 1'b1; end
          CMD_EOR: begin alu_ctl = ALU_EOR; writes_rd = 1'b1; end
          CMD_MOV: begin alu_ctl = ALU_MOV; writes_rd = 1'b1; end
          CMD_CMP: begin alu_ctl = ALU_SUB; arith = 1'b1; end
          default: cmd_ok = 1'b0;
        endcase
      end
      OP_MEM: begin
        imm_src = 2'b01;
        alu_src = 1'b1;
        reg_src = {~l_bit, 1'b0};
        alu_ctl = u_bit ? ALU_ADD : ALU_SUB;
      end
      OP_B: begin
        reg_src = 2'b01;
        imm_src = 2'b10;
        alu_src = 1'b1;
      end
      default: ;
    endcase
  end

  // CMP always updates flags; the other supported commands only with S set.
  assign wr_nz = (op == OP_DP) & cmd_ok & (s_bit | (cmd == CMD_CMP));
  assign wr_cv = wr_nz & arith;

  arm_cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (bus.Instruction[31:28]),
    .alu_flags (bus.ALUFlags),
    .wr_nz     (wr_nz),
    .wr_cv     (wr_cv),
    .flags     (flags),
    .cond_ex   (cond_ex)
  );

  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_inc >= TMO_LIM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    reg_write  = 1'b0;
    pc_write   = 1'b1;
    pc_src     = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      EXEC: begin
        if (is_mem && cond_ex) begin
          mem_req   = 1'b1;
          mem_write = ~l_bit;
          if (bus.mem_ack) begin
            reg_write  = l_bit;
            mem_to_reg = l_bit;
            pc_src     = l_bit & rd15;
          end else begin
            pc_write = 1'b0;
            state_d  = MEM_WAIT;
            cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          reg_write = cond_ex & writes_rd;
          pc_src    = cond_ex & (is_b | (writes_rd & rd15));
        end
      end
      MEM_WAIT: begin
        // An ack arriving in the timeout cycle still commits the access.
        if (bus.mem_ack) begin
          mem_req    = 1'b1;
          mem_write  = ~l_bit;
          reg_write  = l_bit;
          mem_to_reg = l_bit;
          pc_src     = l_bit & rd15;
          state_d    = EXEC;
          cnt_d      = '0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = EXEC;
          cnt_d   = '0;
        end else begin
          mem_req   = 1'b1;
          mem_write = ~l_bit;
          pc_write  = 1'b0;
          cnt_d     = cnt_inc[CNT_W-1:0];
        end
      end
      default: state_d = EXEC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EXEC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset gates every output combinationally so a request drops at once.
  assign bus.RegSrc     = reset ? reg_src    : 2'b00;
  assign bus.ImmSrc     = reset ? imm_src    : 2'b00;
  assign bus.ALUSrc     = reset & alu_src;
  assign bus.ALUControl = reset ? alu_ctl    : 4'b0000;
  assign bus.RegWrite   = reset & reg_write;
  assign bus.MemtoReg   = reset & mem_to_reg;
  assign bus.PCSrc      = reset & pc_src;
  assign bus.MemWrite   = reset & mem_write;
  assign bus.mem_req    = reset & mem_req;
  assign bus.PCWrite    = reset & pc_write;
  assign bus.Flags      = reset ? flags      : 4'b0000;
  assign bus.mem_err    = reset & err_q;
endmodule

// File: tb/tb_arm_mem_stall_controller.sv
// Directed and randomized checks of the control unit against a cycle-level
// reference model of the ARM decode, condition and memory-wait rules.
module tb_arm_mem_stall_controller;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arm_mem_stall_controller_if bus ();

  arm_mem_stall_controller #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] m_flags = 4'b0000;
  int         m_wait  = 0;
  logic       m_err   = 1'b0;
  logic       e_pw    = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: compares this cycle's outputs, then advances its state.
  task automatic model_step(input string tag, input logic [31:0] ins, input logic [3:0] alu, input logic ack);
    logic [1:0] op, rs, is;
    logic [3:0] cmd, ac, nf;
    logic as, rw, mtr, pcs, mw, mr, pw, ok, L, rd15, known, wr, ar, nerr;
    int c, nwait;
    op = ins[27:26]; cmd = ins[24:21]; L = ins[20]; rd15 = (ins[15:12] == 4'hF);
    ok = cond_pass(ins[31:28], m_flags);
    rs = 2'b00; is = 2'b00; as = 1'b0; ac = 4'd0;
    rw = 0; mtr = 0; pcs = 0; mw = 0; mr = 0; pw = 1;
    nf = m_flags; nerr = m_err; nwait = 0;
    if (op == 2'b00) begin
      as = ins[25]; known = 1; wr = 1; ar = 0;
      case (cmd)
        4'd4:  begin ac = 4'd0; ar = 1; end
        4'd2:  begin ac = 4'd1; ar = 1; end
        4'd0:  ac = 4'd2;
        4'd12: ac = 4'd3;
        4'd1:  ac = 4'd4;
        4'd13: ac = 4'd5;
        4'd10: begin ac = 4'd1; ar = 1; wr = 0; end
        default: begin known = 0; wr = 0; end
      endcase
      if (ok && wr) begin rw = 1; pcs = rd15; end
      if (ok && known && (ins[20] || cmd == 4'd10))
        nf = ar ? alu : {alu[3:2], m_flags[1:0]};
    end else if (op == 2'b01) begin
      is = 2'b01; as = 1; rs = {~L, 1'b0}; ac = ins[23] ? 4'd0 : 4'd1;
      if (ok) begin
        c = m_wait + 1;
        if (ack) begin
          mr = 1; mw = ~L; rw = L; mtr = L; pcs = L && rd15;
        end else if (c == TMO) begin
          nerr = 1;
        end else begin
          mr = 1; mw = ~L; pw = 0; nwait = c;
        end
      end
    end else if (op == 2'b10) begin
      rs = 2'b01; is = 2'b10; as = 1; pcs = ok;
    end
    check_val({tag, ".dec"}, {23'd0, bus.RegSrc, bus.ImmSrc, bus.ALUSrc, bus.ALUControl},
              {23'd0, rs, is, as, ac});
    check_val({tag, ".hs"}, {26'd0, bus.RegWrite, bus.MemtoReg, bus.PCSrc, bus.MemWrite, bus.mem_req, bus.PCWrite},
              {26'd0, rw, mtr, pcs, mw, mr, pw});
    check_val({tag, ".flags"}, {28'd0, bus.Flags}, {28'd0, m_flags});
    check_val({tag, ".err"}, {31'd0, bus.mem_err}, {31'd0, m_err});
    e_pw = pw; m_flags = nf; m_err = nerr; m_wait = nwait;
  endtask

  task automatic cyc(input string tag, input logic [31:0] ins, input logic [3:0] alu, input logic ack);
    @(negedge clk);
    bus.Instruction = ins;
    bus.ALUFlags    = alu;
    bus.mem_ack     = ack;
    #1;
    model_step(tag, ins, alu, ack);
  endtask

  function automatic logic [20:0] all_outs();
    return {bus.RegSrc, bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.ALUControl, bus.MemtoReg,
            bus.PCSrc, bus.MemWrite, bus.mem_req, bus.PCWrite, bus.Flags, bus.mem_err};
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val({tag, ".zero"}, {11'd0, all_outs()}, 32'd0);
    bus.Instruction = 32'hF000_0000;
    bus.mem_ack     = 1'b0;
    m_flags = 4'b0000; m_wait = 0; m_err = 1'b0; e_pw = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [3:0]  cmds [8];
    int cls;
    cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0; cmds[3] = 4'd12;
    cmds[4] = 4'd1; cmds[5] = 4'd13; cmds[6] = 4'd10; cmds[7] = 4'($urandom_range(0, 15));
    ins = $urandom;
    if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
    if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
    cls = $urandom_range(0, 9);
    if (cls <= 4) begin
      ins[27:26] = 2'b00;
      ins[24:21] = cmds[$urandom_range(0, 7)];
    end else if (cls <= 7) ins[27:26] = 2'b01;
    else if (cls == 8) ins[27:26] = 2'b10;
    else ins[27:26] = 2'b11;
    return ins;
  endfunction

  initial begin
    logic [31:0] ins;
    int delay, k;
    bus.Instruction = 32'hF000_0000;
    bus.ALUFlags    = 4'b0000;
    bus.mem_ack     = 1'b0;
    #2;
    check_val("por.zero", {11'd0, all_outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    cyc("add", 32'hE281_002A, 4'b1111, 1'b0);
    check_val("add.pcw", {31'd0, bus.PCWrite}, 32'd1);
    check_val("add.rw", {31'd0, bus.RegWrite}, 32'd1);

    cyc("subs", 32'hE253_2000, 4'b0100, 1'b0);
    check_val("subs.ctl", {28'd0, bus.ALUControl}, 32'd1);
    cyc("beq", 32'h0A00_0002, 4'b0000, 1'b0);
    check_val("beq.flags", {28'd0, bus.Flags}, 32'h4);
    check_val("beq.pcsrc", {31'd0, bus.PCSrc}, 32'd1);
    cyc("bne", 32'h1A00_0002, 4'b0000, 1'b0);
    check_val("bne.pcsrc", {31'd0, bus.PCSrc}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      cyc("ldr.wait", 32'hE595_4008, 4'b0000, 1'b0);
      check_val("ldr.wait.rw", {31'd0, bus.RegWrite}, 32'd0);
    end
    cyc("ldr.ack", 32'hE595_4008, 4'b0000, 1'b1);
    check_val("ldr.ack.req", {31'd0, bus.mem_req}, 32'd1);
    check_val("ldr.ack.m2r", {31'd0, bus.MemtoReg}, 32'd1);

    for (int i = 0; i < 15; i++) cyc("str.wait", 32'hE585_4008, 4'b0000, 1'b0);
    cyc("str.tmo", 32'hE585_4008, 4'b0000, 1'b0);
    check_val("str.tmo.req", {31'd0, bus.mem_req}, 32'd0);
    check_val("str.tmo.pcw", {31'd0, bus.PCWrite}, 32'd1);
    cyc("after.tmo", 32'hE281_002A, 4'b0000, 1'b0);
    check_val("after.tmo.err", {31'd0, bus.mem_err}, 32'd1);

    cyc("adds", 32'hE291_0001, 4'b0011, 1'b0);
    cyc("orrs", 32'hE391_0001, 4'b1011, 1'b0);
    cyc("post.orrs", 32'hE281_002A, 4'b0000, 1'b0);
    check_val("orrs.flags", {28'd0, bus.Flags}, 32'hB);

    for (int i = 0; i < 3; i++) cyc("ldr2", 32'hE595_4008, 4'b0000, 1'b0);
    do_reset("midwait");
    cyc("post.rst", 32'hE281_002A, 4'b0000, 1'b0);
    check_val("post.rst.err", {31'd0, bus.mem_err}, 32'd0);
    check_val("post.rst.pcw", {31'd0, bus.PCWrite}, 32'd1);

    for (int i = 0; i < 15; i++) cyc("str2.wait", 32'hE585_4008, 4'b0000, 1'b0);
    cyc("str2.lateack", 32'hE585_4008, 4'b0000, 1'b1);
    cyc("str2.after", 32'hE281_002A, 4'b0000, 1'b0);
    check_val("lateack.err", {31'd0, bus.mem_err}, 32'd0);

    ins = 32'hE281_002A; delay = 0; k = 0;
    for (int n = 0; n < 3000; n++) begin
      if (e_pw) begin
        ins = rand_instr();
        delay = $urandom_range(0, 20);
        k = 0;
      end
      if (ins[27:26] == 2'b01) cyc("rnd", ins, 4'($urandom), (k == delay));
      else                     cyc("rnd", ins, 4'($urandom), 1'($urandom));
      k++;
      if (n % 1000 == 999) do_reset("rnd.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
